// File: rtl/io_arb_pkg.sv
// Shared types for the IO bus arbiter: FSM state encoding and the latched request record.
package io_arb_pkg;

    localparam int IO_N_REQ         = 4;
    localparam int IO_ADDRESS_WIDTH = 32;
    localparam int IO_BUS_WIDTH     = 512;
    localparam int IO_ID_WIDTH      = $clog2(IO_N_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } io_arb_state_t;

    // Request captured at grant time; it drives the device port while the arbiter is busy.
    typedef struct packed {
        logic [IO_ADDRESS_WIDTH-1:0] address;
        logic [IO_BUS_WIDTH-1:0]     data;
        logic                        write;
        logic [IO_ID_WIDTH-1:0]      owner;
    } io_req_t;

endpackage

// File: rtl/io_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module io_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 en_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] winner_o
);

    localparam int IDW = $clog2(N);

    logic           found;
    logic [IDW-1:0] idx;

    // Walk the requesters in priority order; N is a power of two so the index wraps naturally.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_i + IDW'(i);
            if (en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = idx;
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one single-outstanding IO device port among N_REQ requesters, round-robin,
// with one-cycle request strobes, steered read responses and a response watchdog.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int N_REQ         = IO_N_REQ,
    parameter int ADDRESS_WIDTH = IO_ADDRESS_WIDTH,
    parameter int BUS_WIDTH     = IO_BUS_WIDTH,
    parameter int TIMEOUT       = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_write,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0] req_address,
    input  logic [N_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]             req_ack,
    output logic [N_REQ-1:0]             resp_valid,
    output logic                         resp_error,
    output logic [ADDRESS_WIDTH-1:0]     resp_address,
    output logic [BUS_WIDTH-1:0]         resp_data,
    output logic [ADDRESS_WIDTH-1:0]     n2m_request_address,
    output logic [BUS_WIDTH-1:0]         n2m_request_data,
    output logic                         n2m_request_read,
    output logic                         n2m_request_write,
    output logic                         mc_avail_o,
    input  logic                         m2n_request_available,
    input  logic                         m2n_response_valid,
    input  logic [ADDRESS_WIDTH-1:0]     m2n_response_address,
    input  logic [BUS_WIDTH-1:0]         m2n_response_data
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    io_arb_state_t            state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    io_req_t                  req_q, req_d;
    logic [N_REQ-1:0]         resp_valid_q, resp_valid_d;
    logic                     resp_error_q, resp_error_d;
    logic [ADDRESS_WIDTH-1:0] resp_address_q, resp_address_d;
    logic [BUS_WIDTH-1:0]     resp_data_q, resp_data_d;

    logic                     arb_en;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          win_id;

    // Grants only happen in IDLE with the device ready; reset also masks the combinational ack.
    assign arb_en = (state_q == IDLE) && m2n_request_available && !reset;

    io_rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .en_i     (arb_en),
        .grant_o  (grant),
        .winner_o (win_id)
    );

    assign req_ack             = grant;
    assign n2m_request_read    = (state_q == ISSUE) && !req_q.write;
    assign n2m_request_write   = (state_q == ISSUE) &&  req_q.write;
    assign n2m_request_address = req_q.address;
    assign n2m_request_data    = req_q.data;
    assign mc_avail_o          = (state_q == WAIT_RESP);
    assign resp_valid          = resp_valid_q;
    assign resp_error          = resp_error_q;
    assign resp_address        = resp_address_q;
    assign resp_data           = resp_data_q;

    // Next-state logic: grant/latch in IDLE, strobe in ISSUE, response or timeout in WAIT_RESP.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        wd_d           = wd_q;
        req_d          = req_q;
        resp_valid_d   = '0;
        resp_error_d   = 1'b0;
        resp_address_d = resp_address_q;
        resp_data_d    = resp_data_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            req_d.address = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                            req_d.data    = req_data[i*BUS_WIDTH +: BUS_WIDTH];
                            req_d.write   = req_write[i];
                        end
                    end
                    req_d.owner = win_id;
                    ptr_d       = win_id + 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (req_q.write) begin
                    state_d = IDLE;
                end else begin
                    wd_d    = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // Saturating count: the timeout branch leaves the state before it could wrap.
                if (wd_q != WD_LAST) begin
                    wd_d = wd_q + 1'b1;
                end
                // A response in the timeout cycle takes precedence over the error.
                if (m2n_response_valid) begin
                    resp_valid_d   = N_REQ'(1) << req_q.owner;
                    resp_address_d = m2n_response_address;
                    resp_data_d    = m2n_response_data;
                    state_d        = IDLE;
                end else if (wd_q == WD_LAST) begin
                    resp_valid_d   = N_REQ'(1) << req_q.owner;
                    resp_error_d   = 1'b1;
                    resp_address_d = req_q.address;
                    resp_data_d    = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight request without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            wd_q           <= '0;
            req_q          <= '0;
            resp_valid_q   <= '0;
            resp_error_q   <= 1'b0;
            resp_address_q <= '0;
            resp_data_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            wd_q           <= wd_d;
            req_q          <= req_d;
            resp_valid_q   <= resp_valid_d;
            resp_error_q   <= resp_error_d;
            resp_address_q <= resp_address_d;
            resp_data_q    <= resp_data_d;
        end
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the single-outstanding, memory-mapped IO device port (n2m/m2n bus) among `N_REQ` requesters, such as tile IO units or the host interface. Requests are arbitrated round-robin. Each winning read or write is issued as a one-cycle pulse, but only when the device reports it is available. Read responses are steered back to the owning requester, and a response watchdog guarantees every read completes. The block sits between the requester-side IO network and the IO device.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (power of two, ≥2)
- `ADDRESS_WIDTH`, 32, address width
- `BUS_WIDTH`, 512, data bus width
- `TIMEOUT`, 256, maximum number of WAIT_RESP cycles before an error response

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in N_REQ: per-requester request valid, held until acked.
- `req_write` in N_REQ: 1 = write, 0 = read.
- `req_address` in N_REQ×ADDRESS_WIDTH: request address.
- `req_data` in N_REQ×BUS_WIDTH: write data.
- `req_ack` out N_REQ: one-hot; the request is accepted this cycle.
- `resp_valid` out N_REQ: one-hot, one-cycle read completion pulse.
- `resp_error` out 1: qualifies `resp_valid`; 1 = timeout.
- `resp_address` out ADDRESS_WIDTH: address of the completed read.
- `resp_data` out BUS_WIDTH: read data.
- `n2m_request_address` out ADDRESS_WIDTH: to the device.
- `n2m_request_data` out BUS_WIDTH: to the device.
- `n2m_request_read` out 1: read pulse to the device.
- `n2m_request_write` out 1: write pulse to the device.
- `mc_avail_o` out 1: arbiter can sink a response.
- `m2n_request_available` in 1: device can accept a request.
- `m2n_response_valid` in 1: device response valid.
- `m2n_response_address` in ADDRESS_WIDTH: device response address.
- `m2n_response_data` in BUS_WIDTH: device response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
- **IDLE**
  - If `|req_valid` and `m2n_request_available`: the round-robin pick `w` asserts `req_ack[w]` combinationally.
  - On the same edge: latch address, data, kind and owner `w`; set priority pointer to `(w+1) mod N_REQ`; go to ISSUE.
  - If the device is unavailable: no ack, pointer unchanged.
- **ISSUE**
  - Drive `n2m_request_read` or `n2m_request_write` high for exactly this cycle, with the latched address and data.
  - Write: go to IDLE. A write produces no response.
  - Read: clear the watchdog and go to WAIT_RESP.
- **WAIT_RESP**
  - `mc_avail_o` = 1; watchdog increments each cycle.
  - On `m2n_response_valid`: register `m2n_response_data` and `m2n_response_address`; next cycle pulse `resp_valid[owner]` with `resp_error` = 0; go to IDLE.
  - When the watchdog reaches `TIMEOUT`-1 without a response: next cycle pulse `resp_valid[owner]` with `resp_error` = 1, `resp_data` = 0, `resp_address` = latched address; go to IDLE.
- A `m2n_response_valid` that arrives outside WAIT_RESP (a late response) is discarded, with no `resp_valid`.
- In IDLE or ISSUE, `mc_avail_o` = 0.
- Outside ISSUE, `n2m_request_*` strobes are 0; the address and data outputs hold their last latched values.
- Arbitration looks at requests in IDLE only. Requests that arrive while busy wait, and no request is dropped.

## Timing
- Reset values:
  - FSM = IDLE; pointer = 0; watchdog = 0.
  - All strobes, `req_ack`, `resp_valid`, `resp_error` and `mc_avail_o` = 0.
  - Address and data registers = 0.
- `req_ack` is asserted in the same cycle T as the grant; the device strobe fires at T+1.
- Read latency: the device response at cycle R gives `resp_valid` at R+1.
- Back-to-back: after a write, the earliest next grant is T+2, and only if `m2n_request_available` is high.
- Simultaneous events in WAIT_RESP: if the response and the timeout fall in the same cycle, the response wins and `resp_error` = 0.
- Reset asserted mid-operation: the in-flight request is abandoned and no `resp_valid` is issued. The requester re-requests after reset.
- Watchdog width is `$clog2(TIMEOUT)`; it saturates and never wraps.

## Structure
- Package `io_arb_pkg`: `io_arb_state_t` enum (IDLE, ISSUE, WAIT_RESP), `io_req_t` struct (address, data, write, owner id).
- Sub-module `io_rr_arbiter`:
  - Parameter `N`.
  - Inputs: request vector, priority pointer, enable.
  - Outputs: one-hot grant and encoded winner id.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
1. **Single read.** Req0 reads 0x4 with the device available; the device responds 3 cycles after the strobe with data 0xAB.
   - Required: `req_ack[0]` at T, `n2m_request_read` at T+1, `resp_valid[0]` with `resp_data[31:0]` = 0xAB and `resp_error` = 0.
2. **Round-robin under contention.** All four requesters write continuously and the device is always available.
   - Required: ack order 0,1,2,3,0, with a strobe every 2 cycles.
3. **Device busy.** `m2n_request_available` = 0 for 10 cycles while req2 is valid.
   - Required: no ack and no strobe for those 10 cycles; ack on the first available cycle.
4. **Timeout.** `TIMEOUT` = 8 and the device never responds to req1's read.
   - Required: `resp_valid[1]` with `resp_error` = 1 and `resp_data` = 0, 9 cycles after the strobe.
   - Then a late `m2n_response_valid` arrives: no `resp_valid`.
5. **Reset mid-read.** Reset is asserted in WAIT_RESP.
   - Required: all outputs are 0 the same cycle; no `resp_valid` after release; the next grant goes to req0.
6. **Response/timeout collision.** The response arrives exactly in the timeout cycle.
   - Required: a single `resp_valid` with `resp_error` = 0 and the device data.
